// File: rtl/interboard_msg_decoder.sv
// Receive-side decoder for the interboard game protocol: FIFO-buffers peer messages, forwards
// table/hand ops to card memory and tracks turn/cheat/opponent state. RX_ERR_COUNT_EN adds rx_err_cnt.
module interboard_msg_decoder #(
    parameter int PLAYER       = 0,
    parameter int FIFO_DEPTH   = 4,
    parameter int OPP_INIT_CNT = 14
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_en,
    input  logic [3:0] rx_msg_type,
    input  logic       rx_move_dir,
    input  logic [4:0] rx_block_x,
    input  logic [2:0] rx_block_y,
    input  logic [5:0] rx_card,
    input  logic [2:0] rx_sel_len,
    output logic       mem_op_valid,
    input  logic       mem_op_ready,
    output logic [3:0] mem_op_type,
    output logic       mem_op_dir,
    output logic [4:0] mem_op_x,
    output logic [2:0] mem_op_y,
    output logic [5:0] mem_op_card,
    output logic [2:0] mem_op_len,
    output logic       my_turn,
    output logic       cheat_active,
    output logic       game_rst_pulse,
    output logic [6:0] opp_card_cnt,
    output logic       rx_overflow,
    output logic       rx_err_pulse
`ifdef RX_ERR_COUNT_EN
    ,
    output logic [7:0] rx_err_cnt
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [3:0] T_TABLE_DOWN = 4'd1;
    localparam logic [3:0] T_HAND_TAKE  = 4'd3;
    localparam logic [3:0] T_DECK_DRAW  = 4'd5;
    localparam logic [3:0] T_TURN       = 4'd6;
    localparam logic [3:0] T_RST_GAME   = 4'd8;
    localparam logic [3:0] T_CHEAT      = 4'd9;
    localparam logic [6:0] OPP_MAX      = 7'd106;

    typedef struct packed {
        logic [3:0] mtype;
        logic       dir;
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] card;
        logic [2:0] len;
    } msg_t;

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_ISSUE} state_t;

    state_t           state;
    msg_t             fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    msg_t rx_msg, head;
    logic full, bad_type, flush, push, drop, head_is_mem, release_slot;

    assign rx_msg       = '{rx_msg_type, rx_move_dir, rx_block_x, rx_block_y, rx_card, rx_sel_len};
    assign head         = fifo_q[rd_ptr];
    assign full         = (count == CNT_W'(FIFO_DEPTH));
    assign bad_type     = (rx_msg_type > 4'd9);
    assign flush        = (state == S_DECODE) && (head.mtype == T_RST_GAME);
    assign push         = rx_en && !bad_type && !full && !flush;
    assign drop         = rx_en && !flush && (bad_type || full);
    assign head_is_mem  = (head.mtype <= 4'd5) || (head.mtype == 4'd7);
    // A memory op keeps its slot reserved until the memory accepts it, so backpressure
    // from the card memory fills the buffer rather than hiding one extra message.
    assign release_slot = ((state == S_DECODE) && !head_is_mem) ||
                          ((state == S_ISSUE) && mem_op_ready);

    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr] <= rx_msg;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (state == S_DECODE)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(release_slot);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= S_IDLE;
            mem_op_valid   <= 1'b0;
            mem_op_type    <= '0;
            mem_op_dir     <= 1'b0;
            mem_op_x       <= '0;
            mem_op_y       <= '0;
            mem_op_card    <= '0;
            mem_op_len     <= '0;
            my_turn        <= (PLAYER == 0);
            cheat_active   <= 1'b0;
            game_rst_pulse <= 1'b0;
            opp_card_cnt   <= 7'(OPP_INIT_CNT);
            rx_overflow    <= 1'b0;
            rx_err_pulse   <= 1'b0;
        end else begin
            game_rst_pulse <= 1'b0;
            rx_err_pulse   <= drop;
            if (drop && !bad_type)
                rx_overflow <= 1'b1;
            case (state)
                S_IDLE: begin
                    // Looking at the incoming push saves a cycle of decode latency.
                    if (count != '0 || push)
                        state <= S_DECODE;
                end
                S_DECODE: begin
                    state <= S_IDLE;
                    if (head_is_mem) begin
                        state        <= S_ISSUE;
                        mem_op_valid <= 1'b1;
                        mem_op_type  <= head.mtype;
                        mem_op_dir   <= head.dir;
                        mem_op_x     <= head.x;
                        mem_op_y     <= head.y;
                        mem_op_card  <= head.card;
                        mem_op_len   <= head.len;
                    end
                    case (head.mtype)
                        T_HAND_TAKE, T_DECK_DRAW:
                            if (opp_card_cnt != OPP_MAX)
                                opp_card_cnt <= opp_card_cnt + 7'd1;
                        T_TABLE_DOWN:
                            if (opp_card_cnt != 7'd0)
                                opp_card_cnt <= opp_card_cnt - 7'd1;
                        T_TURN:  my_turn      <= !my_turn;
                        T_CHEAT: cheat_active <= !cheat_active;
                        T_RST_GAME: begin
                            game_rst_pulse <= 1'b1;
                            my_turn        <= (PLAYER == 0);
                            cheat_active   <= 1'b0;
                            opp_card_cnt   <= 7'(OPP_INIT_CNT);
                            rx_overflow    <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                S_ISSUE: begin
                    if (mem_op_ready) begin
                        mem_op_valid <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef RX_ERR_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst || flush)
            rx_err_cnt <= '0;
        else if (rx_err_pulse && rx_err_cnt != 8'hff)
            rx_err_cnt <= rx_err_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_interboard_msg_decoder.sv
// Directed bench for interboard_msg_decoder (PLAYER=1): latency, backpressure/overflow,
// turn/cheat toggles, game reset flush, card-count saturation and reset mid-handshake.
module tb_interboard_msg_decoder;
    logic       clk = 1'b0;
    logic       rst;
    logic       rx_en;
    logic [3:0] rx_msg_type;
    logic       rx_move_dir;
    logic [4:0] rx_block_x;
    logic [2:0] rx_block_y;
    logic [5:0] rx_card;
    logic [2:0] rx_sel_len;
    logic       mem_op_valid, mem_op_ready;
    logic [3:0] mem_op_type;
    logic       mem_op_dir;
    logic [4:0] mem_op_x;
    logic [2:0] mem_op_y;
    logic [5:0] mem_op_card;
    logic [2:0] mem_op_len;
    logic       my_turn, cheat_active, game_rst_pulse, rx_overflow, rx_err_pulse;
    logic [6:0] opp_card_cnt;
`ifdef RX_ERR_COUNT_EN
    logic [7:0] rx_err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int rst_pulses = 0;
    logic [5:0] hs_card [$];
    logic [3:0] hs_type [$];

    interboard_msg_decoder #(.PLAYER(1), .FIFO_DEPTH(4), .OPP_INIT_CNT(14)) dut (
        .clk(clk), .rst(rst), .rx_en(rx_en), .rx_msg_type(rx_msg_type),
        .rx_move_dir(rx_move_dir), .rx_block_x(rx_block_x), .rx_block_y(rx_block_y),
        .rx_card(rx_card), .rx_sel_len(rx_sel_len),
        .mem_op_valid(mem_op_valid), .mem_op_ready(mem_op_ready), .mem_op_type(mem_op_type),
        .mem_op_dir(mem_op_dir), .mem_op_x(mem_op_x), .mem_op_y(mem_op_y),
        .mem_op_card(mem_op_card), .mem_op_len(mem_op_len),
        .my_turn(my_turn), .cheat_active(cheat_active), .game_rst_pulse(game_rst_pulse),
        .opp_card_cnt(opp_card_cnt), .rx_overflow(rx_overflow), .rx_err_pulse(rx_err_pulse)
`ifdef RX_ERR_COUNT_EN
        , .rx_err_cnt(rx_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst && mem_op_valid && mem_op_ready) begin
            hs_card.push_back(mem_op_card);
            hs_type.push_back(mem_op_type);
        end
        if (rst && game_rst_pulse)
            rst_pulses <= rst_pulses + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int t, input int x, input int y, input int c);
        rx_msg_type = 4'(t);
        rx_move_dir = 1'b0;
        rx_block_x  = 5'(x);
        rx_block_y  = 3'(y);
        rx_card     = 6'(c);
        rx_sel_len  = 3'd1;
        rx_en       = 1'b1;
    endtask

    // Returns at the falling edge right after the push edge.
    task automatic send(input int t, input int x, input int y, input int c);
        @(negedge clk);
        drive(t, x, y, c);
        @(negedge clk);
        rx_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int base;
        rst = 1'b0; rx_en = 1'b0; rx_msg_type = '0; rx_move_dir = 1'b0; rx_block_x = '0;
        rx_block_y = '0; rx_card = '0; rx_sel_len = '0; mem_op_ready = 1'b0;
        idle(3);
        chk("rst_my_turn", int'(my_turn), 0);
        chk("rst_opp_cnt", int'(opp_card_cnt), 14);
        chk("rst_valid", int'(mem_op_valid), 0);
        chk("rst_overflow", int'(rx_overflow), 0);
        chk("rst_err_pulse", int'(rx_err_pulse), 0);
        rst = 1'b1;
        idle(2);

        // TABLE_DOWN latency and forwarding
        mem_op_ready = 1'b1;
        send(1, 3, 2, 17);
        chk("td_valid_t1", int'(mem_op_valid), 0);
        idle(1);
        chk("td_valid_t2", int'(mem_op_valid), 1);
        chk("td_type", int'(mem_op_type), 1);
        chk("td_x", int'(mem_op_x), 3);
        chk("td_y", int'(mem_op_y), 2);
        chk("td_card", int'(mem_op_card), 17);
        chk("td_opp_cnt", int'(opp_card_cnt), 13);
        idle(1);
        chk("td_valid_t3", int'(mem_op_valid), 0);
        chk("td_hs_count", hs_card.size(), 1);

        // Backpressure: five back-to-back HAND_DRAWs into a depth-4 buffer
        mem_op_ready = 1'b0;
        hs_card.delete(); hs_type.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(4, 0, 0, i + 1);
        end
        @(negedge clk);
        rx_en = 1'b0;
        chk("ovf_err_pulse", int'(rx_err_pulse), 1);
        chk("ovf_sticky", int'(rx_overflow), 1);
        idle(3);
        chk("ovf_hold_valid", int'(mem_op_valid), 1);
        chk("ovf_hold_card", int'(mem_op_card), 1);
        mem_op_ready = 1'b1;
        idle(20);
        chk("ovf_ops_out", hs_card.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("ovf_order", (i < hs_card.size()) ? int'(hs_card[i]) : -1, i + 1);
        chk("ovf_still_set", int'(rx_overflow), 1);
        chk("hd_opp_cnt", int'(opp_card_cnt), 13);

        // Turn and cheat toggles
        hs_card.delete(); hs_type.delete();
        send(6, 0, 0, 0);
        idle(1);
        chk("turn_1", int'(my_turn), 1);
        send(6, 0, 0, 0);
        idle(1);
        chk("turn_2", int'(my_turn), 0);
        chk("turn_no_valid", int'(mem_op_valid), 0);
        send(9, 0, 0, 0);
        idle(1);
        chk("cheat_on", int'(cheat_active), 1);
        send(6, 0, 0, 0);
        idle(2);
        chk("turn_3", int'(my_turn), 1);
        chk("state_no_ops", hs_card.size(), 0);

        // STATE_RST_GAME at head with two messages behind it
        mem_op_ready = 1'b0;
        send(4, 0, 0, 40);
        idle(2);
        send(8, 0, 0, 0);
        send(5, 0, 0, 41);
        send(5, 0, 0, 42);
        base = rst_pulses;
        mem_op_ready = 1'b1;
        idle(15);
        chk("rg_pulses", rst_pulses - base, 1);
        chk("rg_ops_out", hs_card.size(), 1);
        chk("rg_opp_cnt", int'(opp_card_cnt), 14);
        chk("rg_my_turn", int'(my_turn), 0);
        chk("rg_cheat", int'(cheat_active), 0);
        chk("rg_ovf_clr", int'(rx_overflow), 0);

        // Illegal type: dropped, nothing else changes
        hs_card.delete(); hs_type.delete();
        send(12, 0, 0, 0);
        chk("bad_err_pulse", int'(rx_err_pulse), 1);
        idle(2);
        chk("bad_pulse_end", int'(rx_err_pulse), 0);
        chk("bad_no_ovf", int'(rx_overflow), 0);
        chk("bad_my_turn", int'(my_turn), 0);
        chk("bad_opp_cnt", int'(opp_card_cnt), 14);
        chk("bad_no_ops", hs_card.size(), 0);
`ifdef RX_ERR_COUNT_EN
        chk("err_cnt", int'(rx_err_cnt), 1);
`endif

        // Opponent count saturation at 106 and floor at 0
        for (int i = 0; i < 92; i++) begin
            send(5, 0, 0, 0);
            idle(3);
        end
        chk("sat_reach_106", int'(opp_card_cnt), 106);
        send(5, 0, 0, 0);
        idle(3);
        chk("sat_hold_106", int'(opp_card_cnt), 106);
        send(8, 0, 0, 0);
        idle(3);
        chk("sat_rg_14", int'(opp_card_cnt), 14);
        for (int i = 0; i < 14; i++) begin
            send(1, 0, 0, 0);
            idle(3);
        end
        chk("floor_reach_0", int'(opp_card_cnt), 0);
        send(1, 0, 0, 0);
        idle(3);
        chk("floor_hold_0", int'(opp_card_cnt), 0);
        chk("sat_no_ovf", int'(rx_overflow), 0);

        // Reset during a stalled handshake loses the queued message too
        mem_op_ready = 1'b0;
        send(4, 0, 0, 50);
        send(4, 0, 0, 51);
        idle(1);
        chk("mrst_valid_pre", int'(mem_op_valid), 1);
        rst = 1'b0;
        idle(1);
        chk("mrst_valid_drop", int'(mem_op_valid), 0);
        rst = 1'b1;
        hs_card.delete(); hs_type.delete();
        mem_op_ready = 1'b1;
        idle(10);
        chk("mrst_no_ops", hs_card.size(), 0);
        chk("mrst_opp_cnt", int'(opp_card_cnt), 14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
